// File: rtl/pport_nibble_tx_pkg.sv
// pport_pkg: shared state encoding, handshake constants and the cp glitch-filter helper.
package pport_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_READY = 2'd2,
        ST_ACKLO = 2'd3
    } state_t;

    localparam logic NIBBLE_HI_FIRST = 1'b1;
    localparam logic CP_IDLE_LEVEL   = 1'b1;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/pport_nibble_tx_if.sv
// pport_nibble_tx_if: byte-input handshake plus the nibble/acknowledge link to the bridge.
interface pport_nibble_tx_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       pport_cp;
    logic [3:0] remote_d;
    logic       remote_data_ready;

    modport master (
        output in_valid, in_data, pport_cp,
        input  in_ready, remote_d, remote_data_ready
    );

    modport slave (
        input  in_valid, in_data, pport_cp,
        output in_ready, remote_d, remote_data_ready
    );
endinterface

// File: rtl/pport_nibble_tx_fifo.sv
// pport_byte_fifo: synchronous first-word-fall-through byte FIFO with level output.
module pport_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          wr, rd;

    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    // a simultaneous pop frees the slot being written, so a full FIFO can still take a push
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    assign dout  = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            level <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;
endmodule

// File: rtl/pport_nibble_tx.sv
// pport_nibble_tx: buffers bytes and sends them high nibble first, one nibble per pport_cp low pulse.
// Define PPORT_TIMEOUT_EN to abort a stalled handshake and raise the sticky timeout_err flag.
module pport_nibble_tx
    import pport_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 16,
    parameter int          FIFO_AW        = 4,
    parameter int          SETUP_CYCLES   = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                 clk,
    input  logic                 cold_reset,
    pport_nibble_tx_if.slave     bus,
    output logic [FIFO_AW:0]     fifo_level,
    output logic                 busy,
    input  logic                 clr_err,
    output logic                 timeout_err
);
    localparam int SW = $clog2(SETUP_CYCLES + 1);

    state_t        state, state_n;
    logic [7:0]    hold, hold_n;
    logic          nib_sel, nib_n;
    logic [3:0]    d_n;
    logic          rdy_n;
    logic [SW-1:0] cnt, cnt_n;
    logic          load, pop, to;
    logic [7:0]    dout;
    logic          full, empty;
    logic          cp_s1, cp_s2, cp_f;
    logic [2:0]    cp_h;

    pport_byte_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (cold_reset),
        .push  (bus.in_valid && bus.in_ready),
        .din   (bus.in_data),
        .pop   (pop),
        .dout  (dout),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready = !full;
    assign busy         = state != ST_IDLE;
    assign cp_f         = maj3(cp_h);

    // pport_cp is asynchronous: synchronise, then reject single-sample glitches
    always_ff @(posedge clk or posedge cold_reset) begin
        if (cold_reset) begin
            cp_s1 <= CP_IDLE_LEVEL;
            cp_s2 <= CP_IDLE_LEVEL;
            cp_h  <= {3{CP_IDLE_LEVEL}};
        end else begin
            cp_s1 <= bus.pport_cp;
            cp_s2 <= cp_s1;
            cp_h  <= {cp_h[1:0], cp_s2};
        end
    end

`ifdef PPORT_TIMEOUT_EN
    logic [23:0] tcnt;
    logic        waiting;

    assign waiting = state == ST_READY || state == ST_ACKLO;
    assign to      = waiting && tcnt == TIMEOUT_CYCLES - 24'd1;

    always_ff @(posedge clk or posedge cold_reset) begin
        if (cold_reset) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= (waiting && !to) ? tcnt + 24'd1 : '0;
            timeout_err <= clr_err ? 1'b0 : (timeout_err | to);
        end
    end
`else
    logic unused_cfg;

    assign to          = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = clr_err ^ (^TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_n = state;
        hold_n  = hold;
        nib_n   = nib_sel;
        d_n     = bus.remote_d;
        rdy_n   = bus.remote_data_ready;
        cnt_n   = cnt;
        load    = 1'b0;
        pop     = 1'b0;
        if (to) begin
            state_n = ST_IDLE;
            rdy_n   = 1'b0;
        end else begin
            case (state)
                ST_IDLE:  load = !empty;
                ST_SETUP: begin
                    cnt_n = cnt + SW'(1);
                    if (cnt == SW'(SETUP_CYCLES)) begin
                        rdy_n   = 1'b1;
                        state_n = ST_READY;
                    end
                end
                ST_READY: state_n = cp_f ? ST_READY : ST_ACKLO;
                ST_ACKLO: if (cp_f) begin
                    rdy_n = 1'b0;
                    cnt_n = '0;
                    if (nib_sel) begin
                        d_n     = hold[3:0];
                        nib_n   = 1'b0;
                        state_n = ST_SETUP;
                    end else begin
                        load    = !empty;
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        if (load) begin
            pop     = 1'b1;
            hold_n  = dout;
            nib_n   = NIBBLE_HI_FIRST;
            d_n     = dout[7:4];
            cnt_n   = '0;
            state_n = ST_SETUP;
        end
    end

    always_ff @(posedge clk or posedge cold_reset) begin
        if (cold_reset) begin
            state                 <= ST_IDLE;
            hold                  <= '0;
            nib_sel               <= 1'b0;
            cnt                   <= '0;
            bus.remote_d          <= '0;
            bus.remote_data_ready <= 1'b0;
        end else begin
            state                 <= state_n;
            hold                  <= hold_n;
            nib_sel               <= nib_n;
            cnt                   <= cnt_n;
            bus.remote_d          <= d_n;
            bus.remote_data_ready <= rdy_n;
        end
    end
endmodule

// File: tb/tb_pport_nibble_tx.sv
// tb_pport_nibble_tx: directed self-checking bench for pport_nibble_tx.
module tb_pport_nibble_tx;
    logic       clk = 1'b0;
    logic       cold_reset;
    logic       clr_err;
    logic [4:0] fifo_level;
    logic       busy;
    logic       timeout_err;
    int         checks = 0;
    int         failures = 0;

    pport_nibble_tx_if bus ();

    pport_nibble_tx #(
        .FIFO_DEPTH     (16),
        .FIFO_AW        (4),
        .SETUP_CYCLES   (4),
        .TIMEOUT_CYCLES (24'd100)
    ) dut (
        .clk         (clk),
        .cold_reset  (cold_reset),
        .bus         (bus),
        .fifo_level  (fifo_level),
        .busy        (busy),
        .clr_err     (clr_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack;
        bus.pport_cp = 1'b0;
        repeat (8) tick();
        bus.pport_cp = 1'b1;
    endtask

    task automatic wait_rdy(input logic v, input string tag);
        int n = 0;
        while (bus.remote_data_ready !== v && n < 60) begin
            tick();
            n++;
        end
        chk(tag, bus.remote_data_ready, v);
    endtask

    initial begin
        cold_reset   = 1'b1;
        clr_err      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.pport_cp = 1'b1;
        repeat (3) tick();
        chk("rst_d", bus.remote_d, 0);
        chk("rst_rdy", bus.remote_data_ready, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        cold_reset = 1'b0;
        repeat (3) tick();

        // byte 0xA5: latency from push, nibble order, latency after ack
        push_byte(8'hA5);
        chk("a5_level_after_push", fifo_level, 1);
        chk("a5_idle_at_push", busy, 0);
        repeat (5) tick();
        chk("a5_rdy_before_setup", bus.remote_data_ready, 0);
        tick();
        chk("a5_rdy_latency", bus.remote_data_ready, 1);
        chk("a5_hi_nibble", bus.remote_d, 4'hA);
        chk("a5_level_popped", fifo_level, 0);
        ack();
        wait_rdy(1'b0, "a5_ack1_drop");
        repeat (4) tick();
        chk("a5_rdy_in_setup", bus.remote_data_ready, 0);
        chk("a5_lo_nibble_setup", bus.remote_d, 4'h5);
        tick();
        chk("a5_rdy_after_ack", bus.remote_data_ready, 1);
        chk("a5_lo_nibble", bus.remote_d, 4'h5);
        ack();
        wait_rdy(1'b0, "a5_ack2_drop");
        chk("a5_idle", busy, 0);
        chk("a5_d_held", bus.remote_d, 4'h5);

        // pulse with nothing to send is ignored
        ack();
        repeat (8) tick();
        chk("idle_pulse_busy", busy, 0);
        chk("idle_pulse_rdy", bus.remote_data_ready, 0);
        chk("idle_pulse_d", bus.remote_d, 4'h5);

        // single-cycle glitch during READY must not advance
        push_byte(8'h7E);
        wait_rdy(1'b1, "glitch_rdy");
        chk("glitch_hi", bus.remote_d, 4'h7);
        bus.pport_cp = 1'b0;
        tick();
        bus.pport_cp = 1'b1;
        repeat (10) tick();
        chk("glitch_rdy_held", bus.remote_data_ready, 1);
        chk("glitch_d_held", bus.remote_d, 4'h7);
        ack();
        wait_rdy(1'b0, "glitch_ack1_drop");
        wait_rdy(1'b1, "glitch_ack1_rise");
        chk("glitch_lo", bus.remote_d, 4'hE);
        ack();
        wait_rdy(1'b0, "glitch_ack2_drop");
        chk("glitch_idle", busy, 0);

        // cold_reset between the two acks of 0x3C with another byte queued
        push_byte(8'h3C);
        push_byte(8'h55);
        wait_rdy(1'b1, "rst_mid_rdy");
        chk("rst_mid_hi", bus.remote_d, 4'h3);
        ack();
        wait_rdy(1'b0, "rst_mid_ack_drop");
        wait_rdy(1'b1, "rst_mid_ack_rise");
        chk("rst_mid_lo", bus.remote_d, 4'hC);
        cold_reset = 1'b1;
        #1;
        chk("rst_mid_d", bus.remote_d, 0);
        chk("rst_mid_rdy0", bus.remote_data_ready, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);
        tick();
        cold_reset = 1'b0;
        repeat (12) tick();
        chk("rst_after_rdy", bus.remote_data_ready, 0);
        chk("rst_after_busy", busy, 0);
        chk("rst_after_d", bus.remote_d, 0);

        // 17 back-to-back bytes fill hold + 16 FIFO entries
        bus.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.in_data = 8'h10 + 8'(i);
            tick();
        end
        bus.in_data = 8'hEE;
        chk("full_level", fifo_level, 16);
        chk("full_in_ready", bus.in_ready, 0);
        tick();
        bus.in_valid = 1'b0;
        chk("full_drop_level", fifo_level, 16);
        wait_rdy(1'b1, "full_rdy");
        chk("full_b0_hi", bus.remote_d, 4'h1);
        ack();
        wait_rdy(1'b0, "full_ack1_drop");
        wait_rdy(1'b1, "full_ack1_rise");
        chk("full_b0_lo", bus.remote_d, 4'h0);
        chk("full_still_full", bus.in_ready, 0);
        ack();
        wait_rdy(1'b0, "full_ack2_drop");
        chk("full_freed_level", fifo_level, 15);
        chk("full_freed_in_ready", bus.in_ready, 1);
        chk("full_next_busy", busy, 1);
        push_byte(8'h99);
        chk("full_refill_level", fifo_level, 16);
        wait_rdy(1'b1, "full_b1_rdy");
        chk("full_b1_hi", bus.remote_d, 4'h1);
        ack();
        wait_rdy(1'b0, "full_b1_drop");
        wait_rdy(1'b1, "full_b1_rise");
        chk("full_b1_lo", bus.remote_d, 4'h1);
        cold_reset = 1'b1;
        tick();
        cold_reset = 1'b0;
        repeat (3) tick();
        chk("full_reset_level", fifo_level, 0);

`ifdef PPORT_TIMEOUT_EN
        push_byte(8'h12);
        push_byte(8'h34);
        wait_rdy(1'b1, "to_rdy");
        chk("to_hi", bus.remote_d, 4'h1);
        repeat (99) tick();
        chk("to_not_yet", timeout_err, 0);
        tick();
        chk("to_err", timeout_err, 1);
        chk("to_rdy_drop", bus.remote_data_ready, 0);
        wait_rdy(1'b1, "to_next_rdy");
        chk("to_next_hi", bus.remote_d, 4'h3);
        chk("to_err_sticky", timeout_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_clr", timeout_err, 0);
`else
        push_byte(8'h12);
        wait_rdy(1'b1, "nto_rdy");
        clr_err = 1'b1;
        repeat (150) tick();
        clr_err = 1'b0;
        chk("nto_err", timeout_err, 0);
        chk("nto_rdy_held", bus.remote_data_ready, 1);
        chk("nto_d", bus.remote_d, 4'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
